vc_fifo_flow: RTL and testbench

//  Virtual-channel FIFO that feeds the VC flow-control FSM: buffers data words and reports

---
 rtl/vc_fifo_flow_pkg.sv | 23 ++
 rtl/vc_fifo_flow_if.sv | 33 +++
 rtl/vc_fifo_flow_fifo_mem.sv | 33 +++
 rtl/vc_fifo_flow.sv | 72 +++++++
 tb/tb_vc_fifo_flow.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/vc_fifo_flow_pkg.sv
// vc_fifo_flow_pkg
//  Shared widths, depth, threshold field slices and reset threshold defaults
//  for the VC FIFO and its flow-control neighbours (FSM, arbiter).
package vc_fifo_flow_pkg;
  localparam int DATA_W = 6;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THR_HI_RST   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] THR_LO_RST   = CNT_W'(1);

  // umbrales_VCFC layout: [7:4] high threshold, [3:0] low threshold.
  // Both are zero-extended to occupancy width so compares are unsigned.
  function automatic logic [CNT_W-1:0] thr_hi(input logic [7:0] u);
    return CNT_W'(u[7:4]);
  endfunction

  function automatic logic [CNT_W-1:0] thr_lo(input logic [7:0] u);
    return CNT_W'(u[3:0]);
  endfunction
endpackage

// File: rtl/vc_fifo_flow_if.sv
// vc_fifo_flow_if
//  Push/pop/threshold bus between the VC arbiter + flow-control FSM (master)
//  and the VC FIFO (slave).
//  master drives: push, data_in, pop, umbrales_VCFC
//  slave  drives: data_out, fifo_empty, fifo_full, almost_full, almost_empty,
//                 fifo_error, count
interface vc_fifo_flow_if;
  import vc_fifo_flow_pkg::*;

  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [7:0]        umbrales_VCFC;
  logic [DATA_W-1:0] data_out;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_full;
  logic              almost_empty;
  logic              fifo_error;
  logic [CNT_W-1:0]  count;

  modport master (
    output push, data_in, pop, umbrales_VCFC,
    input  data_out, fifo_empty, fifo_full, almost_full, almost_empty,
           fifo_error, count
  );

  modport slave (
    input  push, data_in, pop, umbrales_VCFC,
    output data_out, fifo_empty, fifo_full, almost_full, almost_empty,
           fifo_error, count
  );
endinterface

// File: rtl/vc_fifo_flow_fifo_mem.sv
// fifo_mem
//  DEPTH x DW register array, one write port, one registered read port with
//  read enable. The read register resets to 0 and holds when i_rd_en is low;
//  the array itself is not reset.
//  i_clk, i_rst_n        clock, async active-low reset (read register only)
//  i_wr_en/addr/data     write port
//  i_rd_en/addr          read request, data appears on o_rd_data next cycle
//  o_rd_data             registered read data
module fifo_mem #(
  parameter int DW = 6,
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);
  logic [DW-1:0] r_mem [1<<AW];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Same-address read+write (full FIFO, push+pop) returns the old word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/vc_fifo_flow.sv
// vc_fifo_flow
//  Virtual-channel FIFO feeding the VC flow-control FSM. Buffers words from
//  the VC arbiter, reports empty/full/error and raises almost_full /
//  almost_empty against thresholds captured from umbrales_VCFC.
//  clk      single clock, posedge
//  reset_L  async active-low reset; drops all buffered data
//  bus      vc_fifo_flow_if.slave (push/pop/data/thresholds in, flags out)
module vc_fifo_flow
  import vc_fifo_flow_pkg::*;
(
  input  logic          clk,
  input  logic          reset_L,
  vc_fifo_flow_if.slave bus
);
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, r_thr_hi, r_thr_lo;
  logic              r_err;

  logic w_empty, w_full, w_push_ok, w_pop_ok, w_ovf, w_udf;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  // A pop on a full FIFO frees the slot this same edge, so push still goes in.
  assign w_push_ok = bus.push && (!w_full || bus.pop);
  assign w_pop_ok  = bus.pop && !w_empty;
  assign w_ovf     = bus.push && w_full && !bus.pop;
  assign w_udf     = bus.pop && w_empty;

  fifo_mem #(.DW(DATA_W), .AW(ADDR_W)) u_mem (
    .i_clk     (clk),
    .i_rst_n   (reset_L),
    .i_wr_en   (w_push_ok),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.data_in),
    .i_rd_en   (w_pop_ok),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (bus.data_out)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_thr_hi <= THR_HI_RST;
      r_thr_lo <= THR_LO_RST;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf || w_udf) r_err <= 1'b1;
      // The FSM drives zero outside INIT/IDLE/ACTIVE; zero means "keep".
      if (bus.umbrales_VCFC != 8'h00) begin
        r_thr_hi <= thr_hi(bus.umbrales_VCFC);
        r_thr_lo <= thr_lo(bus.umbrales_VCFC);
      end
    end
  end

  // Flags decode registered state only.
  assign bus.fifo_empty   = w_empty;
  assign bus.fifo_full    = w_full;
  assign bus.almost_full  = (r_count >= r_thr_hi);
  assign bus.almost_empty = (r_count <= r_thr_lo);
  assign bus.fifo_error   = r_err;
  assign bus.count        = r_count;
endmodule

// File: tb/tb_vc_fifo_flow.sv
module tb_vc_fifo_flow;
  import vc_fifo_flow_pkg::*;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  vc_fifo_flow_if vif();

  vc_fifo_flow dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (vif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs settle before it, outputs sampled 1 time unit after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vif.push = 1'b0;
    vif.pop  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_L = 1'b0;
    step();
    reset_L = 1'b1;
    step();
  endtask

  initial begin
    vif.push = 1'b0;
    vif.pop  = 1'b0;
    vif.data_in = '0;
    vif.umbrales_VCFC = 8'h00;

    // ---- 1: reset state, 3 push / 3 pop with thresholds 6/2
    reset_L = 1'b0;
    step(); step();
    chk("rst_count", 32'(vif.count), 0);
    chk("rst_empty", 32'(vif.fifo_empty), 1);
    chk("rst_full", 32'(vif.fifo_full), 0);
    chk("rst_aempty", 32'(vif.almost_empty), 1);
    chk("rst_afull", 32'(vif.almost_full), 0);
    chk("rst_err", 32'(vif.fifo_error), 0);
    chk("rst_dout", 32'(vif.data_out), 0);
    reset_L = 1'b1;
    step();

    vif.umbrales_VCFC = 8'h62;
    vif.push = 1'b1;
    vif.data_in = 6'h11; step();
    vif.umbrales_VCFC = 8'h00;
    vif.data_in = 6'h22; step();
    chk("t1_ae_cnt2", 32'(vif.almost_empty), 1);
    vif.data_in = 6'h33; step();
    idle();
    chk("t1_count3", 32'(vif.count), 3);
    chk("t1_aempty", 32'(vif.almost_empty), 0);
    chk("t1_afull", 32'(vif.almost_full), 0);
    vif.pop = 1'b1; step();
    chk("t1_pop1", 32'(vif.data_out), 32'h11);
    step();
    chk("t1_pop2", 32'(vif.data_out), 32'h22);
    step();
    chk("t1_pop3", 32'(vif.data_out), 32'h33);
    idle(); step();
    chk("t1_hold", 32'(vif.data_out), 32'h33);
    chk("t1_empty", 32'(vif.fifo_empty), 1);

    // ---- 2: fill to full, overflow, oldest word survives
    vif.push = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vif.data_in = 6'(i);
      step();
      if (i == 5) chk("t2_af_at5", 32'(vif.almost_full), 0);
      if (i == 6) chk("t2_af_at6", 32'(vif.almost_full), 1);
      if (i == 7) chk("t2_full_at7", 32'(vif.fifo_full), 0);
    end
    chk("t2_full", 32'(vif.fifo_full), 1);
    chk("t2_err_pre", 32'(vif.fifo_error), 0);
    vif.data_in = 6'h3F; step();
    idle();
    chk("t2_ovf_err", 32'(vif.fifo_error), 1);
    chk("t2_ovf_cnt", 32'(vif.count), 8);
    vif.pop = 1'b1; step(); idle();
    chk("t2_first", 32'(vif.data_out), 1);
    chk("t2_cnt7", 32'(vif.count), 7);

    // ---- 3: underflow, push+pop on empty, sticky error cleared by reset
    do_reset();
    chk("t3_rst_err", 32'(vif.fifo_error), 0);
    vif.pop = 1'b1; step(); idle();
    chk("t3_udf_err", 32'(vif.fifo_error), 1);
    chk("t3_udf_dout", 32'(vif.data_out), 0);
    vif.push = 1'b1; vif.pop = 1'b1; vif.data_in = 6'h2A; step(); idle();
    chk("t3_pp_cnt", 32'(vif.count), 1);
    chk("t3_pp_dout", 32'(vif.data_out), 0);
    chk("t3_sticky", 32'(vif.fifo_error), 1);
    step();
    chk("t3_sticky2", 32'(vif.fifo_error), 1);
    do_reset();
    chk("t3_clr_err", 32'(vif.fifo_error), 0);
    chk("t3_clr_cnt", 32'(vif.count), 0);

    // ---- 4: full FIFO, push+pop across pointer wrap
    vif.push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vif.data_in = 6'(8'h10 + i);
      step();
    end
    vif.pop = 1'b1;
    for (int k = 0; k < 10; k++) begin
      vif.data_in = 6'(8'h20 + k);
      step();
      chk("t4_cnt", 32'(vif.count), 8);
      chk("t4_data", 32'(vif.data_out), (k < 8) ? 32'(8'h10 + k) : 32'(8'h20 + k - 8));
    end
    idle();
    chk("t4_err", 32'(vif.fifo_error), 0);

    // ---- 5: thresholds 5/3 survive umbrales=0
    do_reset();
    vif.umbrales_VCFC = 8'h53; step();
    vif.umbrales_VCFC = 8'h00; step(); step();
    vif.push = 1'b1;
    for (int i = 0; i < 3; i++) begin vif.data_in = 6'(i); step(); end
    idle();
    chk("t5_ae_cnt3", 32'(vif.almost_empty), 1);
    chk("t5_af_cnt3", 32'(vif.almost_full), 0);
    vif.push = 1'b1; step(); idle();
    chk("t5_ae_cnt4", 32'(vif.almost_empty), 0);
    chk("t5_af_cnt4", 32'(vif.almost_full), 0);
    vif.push = 1'b1; step(); idle();
    chk("t5_af_cnt5", 32'(vif.almost_full), 1);
    chk("t5_cnt5", 32'(vif.count), 5);

    // ---- 6: async reset between edges with count=4
    vif.pop = 1'b1; step(); idle();
    chk("t6_cnt4", 32'(vif.count), 4);
    chk("t6_dout_pre", 32'(vif.data_out), 0);
    vif.pop = 1'b1; step(); idle();
    chk("t6_dout1", 32'(vif.data_out), 1);
    vif.push = 1'b1; vif.data_in = 6'h05; step(); idle();
    chk("t6_cnt4b", 32'(vif.count), 4);
    #2;
    reset_L = 1'b0;
    #1;
    chk("t6_async_cnt", 32'(vif.count), 0);
    chk("t6_async_empty", 32'(vif.fifo_empty), 1);
    chk("t6_async_dout", 32'(vif.data_out), 0);
    chk("t6_async_ae", 32'(vif.almost_empty), 1);
    step();
    reset_L = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
